grad_mux_sequencer: RTL and testbench

Digital valve sequencer that drives the four pneumatic control lines of the gradient device's 4-outlet MUX (cpb1_1, cpb1_2, cpb2_1, cpb2_2) and the gradient source enable (pb1/pb2 pressure). Sits directly upstream of the device's control ports and routes the gradient output into each enabled long cell trap in turn. Every lane change is break-before-make: all valves close, a settle interval elapses, then the next lane opens for a programmed dwell.

---
 rtl/grad_mux_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_grad_mux_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/grad_mux_sequencer.sv
// Break-before-make valve sequencer for the 4-outlet gradient MUX.
// Each enabled lane is served in ascending order: all valves closed for a settle interval, then one lane filled.
module grad_mux_sequencer #(
  parameter int DWELL_W  = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [3:0]          lane_mask,
  input  logic [DWELL_W-1:0]  dwell_cycles,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                cpb1_1,
  output logic                cpb1_2,
  output logic                cpb2_1,
  output logic                cpb2_2,
  output logic                src_en,
  output logic                busy,
  output logic [1:0]          lane,
  output logic                lane_valid,
  output logic                done
);

  localparam int CNT_W = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FILL   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          mask_r, mask_s;
  logic [DWELL_W-1:0]  dwell_r, dwell_s;
  logic [SETTLE_W-1:0] settle_r, settle_s;
  logic [1:0]          lane_r, lane_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [2:0]          find_s;

  logic [3:0] valves_s;
  logic       src_en_s;
  logic       busy_s;
  logic [1:0] lane_out_s;
  logic       lane_valid_s;
  logic       done_s;

  // Lowest set bit of mask at or above position from; bit 2 flags that one was found.
  function automatic logic [2:0] find_lane(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(from)) && mask[i]) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  // Counters hold "cycles remaining minus one", so a zero request still yields one cycle.
  function automatic logic [CNT_W-1:0] settle_load(input logic [SETTLE_W-1:0] s);
    if (s == {SETTLE_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return CNT_W'(s - SETTLE_W'(1));
    end
  endfunction

  function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    if (d == {DWELL_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return CNT_W'(d - DWELL_W'(1));
    end
  endfunction

  // State and latched-run registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      mask_r   <= 4'b0000;
      dwell_r  <= {DWELL_W{1'b0}};
      settle_r <= {SETTLE_W{1'b0}};
      lane_r   <= 2'd0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      mask_r   <= mask_s;
      dwell_r  <= dwell_s;
      settle_r <= settle_s;
      lane_r   <= lane_s;
      cnt_r    <= cnt_s;
    end
  end

  // Next-state, lane selection and counter control.
  always_comb begin
    state_s  = state_r;
    mask_s   = mask_r;
    dwell_s  = dwell_r;
    settle_s = settle_r;
    lane_s   = lane_r;
    cnt_s    = cnt_r;
    find_s   = 3'b000;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mask_s   = lane_mask;
            dwell_s  = dwell_cycles;
            settle_s = settle_cycles;
            find_s   = find_lane(lane_mask, 3'd0);
            if (find_s[2]) begin
              state_s = ST_SETTLE;
              lane_s  = find_s[1:0];
              cnt_s   = settle_load(settle_cycles);
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_s = ST_FILL;
            cnt_s   = dwell_load(dwell_r);
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        ST_FILL: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            find_s = find_lane(mask_r, {1'b0, lane_r} + 3'd1);
            if (find_s[2]) begin
              state_s = ST_SETTLE;
              lane_s  = find_s[1:0];
              cnt_s   = settle_load(settle_r);
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Moore output decode of the upcoming state; valves default to closed.
  always_comb begin
    valves_s     = 4'b1111;
    src_en_s     = 1'b0;
    busy_s       = 1'b0;
    lane_out_s   = 2'd0;
    lane_valid_s = 1'b0;
    done_s       = 1'b0;
    case (state_s)
      ST_FILL: begin
        valves_s     = {lane_s[1], ~lane_s[1], lane_s[0], ~lane_s[0]};
        src_en_s     = 1'b1;
        busy_s       = 1'b1;
        lane_out_s   = lane_s;
        lane_valid_s = 1'b1;
      end
      ST_SETTLE: begin
        busy_s = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset drives every valve closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpb1_1     <= 1'b1;
      cpb1_2     <= 1'b1;
      cpb2_1     <= 1'b1;
      cpb2_2     <= 1'b1;
      src_en     <= 1'b0;
      busy       <= 1'b0;
      lane       <= 2'd0;
      lane_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      cpb1_1     <= valves_s[3];
      cpb1_2     <= valves_s[2];
      cpb2_1     <= valves_s[1];
      cpb2_2     <= valves_s[0];
      src_en     <= src_en_s;
      busy       <= busy_s;
      lane       <= lane_out_s;
      lane_valid <= lane_valid_s;
      done       <= done_s;
    end
  end

endmodule

// File: tb/tb_grad_mux_sequencer.sv
// Directed bench for grad_mux_sequencer: lane order, valve patterns, timing, abort and async reset.
// Output vector layout: {cpb1_1, cpb1_2, cpb2_1, cpb2_2, src_en, busy, lane[1:0], lane_valid, done}.
module tb_grad_mux_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  lane_mask;
  logic [15:0] dwell_cycles;
  logic [7:0]  settle_cycles;
  logic        cpb1_1, cpb1_2, cpb2_1, cpb2_2;
  logic        src_en, busy, lane_valid, done;
  logic [1:0]  lane;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  localparam logic [9:0] IDLE_V   = 10'b1111_0_0_00_0_0;
  localparam logic [9:0] SETTLE_V = 10'b1111_0_1_00_0_0;
  localparam logic [9:0] DONE_V   = 10'b1111_0_0_00_0_1;

  grad_mux_sequencer #(.DWELL_W(16), .SETTLE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .lane_mask(lane_mask), .dwell_cycles(dwell_cycles), .settle_cycles(settle_cycles),
    .cpb1_1(cpb1_1), .cpb1_2(cpb1_2), .cpb2_1(cpb2_1), .cpb2_2(cpb2_2),
    .src_en(src_en), .busy(busy), .lane(lane), .lane_valid(lane_valid), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] obs();
    return {cpb1_1, cpb1_2, cpb2_1, cpb2_2, src_en, busy, lane, lane_valid, done};
  endfunction

  // Fill pattern for lane l: closing a valve blocks its branch.
  function automatic logic [9:0] fill_vec(input logic [1:0] l);
    return {l[1], ~l[1], l[0], ~l[0], 1'b1, 1'b1, l, 1'b1, 1'b0};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Starts a run from a negedge and checks every cycle against the expected timeline.
  task automatic run_check(input string tag, input logic [3:0] m, input int s, input int d,
                           input int exp_done, input bit disturb);
    logic [9:0] q[$];
    int s_eff, d_eff, done_cyc;
    s_eff    = (s == 0) ? 1 : s;
    d_eff    = (d == 0) ? 1 : d;
    done_cyc = -1;
    for (int l = 0; l < 4; l++) begin
      if (m[l]) begin
        for (int i = 0; i < s_eff; i++) q.push_back(SETTLE_V);
        for (int i = 0; i < d_eff; i++) q.push_back(fill_vec(2'(l)));
      end
    end
    q.push_back(DONE_V);
    q.push_back(IDLE_V);
    lane_mask     = m;
    settle_cycles = 8'(s);
    dwell_cycles  = 16'(d);
    start         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= q.size(); c++) begin
      if (c > 1) @(negedge clk);
      check_eq($sformatf("%s_c%0d", tag, c), 32'(obs()), 32'(q[c-1]));
      if (done && done_cyc < 0) done_cyc = c;
      if (disturb && c == 2) begin
        start         = 1'b1;
        lane_mask     = 4'b0001;
        settle_cycles = 8'd0;
        dwell_cycles  = 16'd0;
      end else if (disturb && c == 3) begin
        start = 1'b0;
      end
    end
    check_eq({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    lane_mask     = 4'b0000;
    dwell_cycles  = 16'd0;
    settle_cycles = 8'd0;
    #12;
    check_eq("reset_vals", 32'(obs()), 32'(IDLE_V));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_check("single", 4'b0001, 3, 5, 9, 1'b0);
    run_check("sweep", 4'b1111, 2, 4, 25, 1'b1);
    run_check("sparse", 4'b1010, 0, 0, 5, 1'b0);
    run_check("empty", 4'b0000, 4, 4, 1, 1'b0);

    // start and abort together in IDLE: abort wins.
    lane_mask = 4'b0001; settle_cycles = 8'd1; dwell_cycles = 16'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_eq("start_abort_idle", 32'(obs()), 32'(IDLE_V));
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("start_abort_idle2", 32'(obs()), 32'(IDLE_V));

    // Abort during FILL of lane 2 (cycles 15..18 with S=2, D=4, mask 1111).
    lane_mask = 4'b1111; settle_cycles = 8'd2; dwell_cycles = 16'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("abort_pre_lane2", 32'(obs()), 32'(fill_vec(2'd2)));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_safe", 32'(obs()), 32'(IDLE_V));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("abort_nodone_%0d", i), 32'(obs()), 32'(IDLE_V));
    end
    run_check("after_abort", 4'b1111, 1, 1, 9, 1'b0);

    // Async reset mid-FILL of lane 2 (settle cycle 1, fill cycles 2..7).
    lane_mask = 4'b0100; settle_cycles = 8'd1; dwell_cycles = 16'd6;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("rst_run_settle", 32'(obs()), 32'(SETTLE_V));
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_run_fill", 32'(obs()), 32'(fill_vec(2'd2)));
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", 32'(obs()), 32'(IDLE_V));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_idle", 32'(obs()), 32'(IDLE_V));
    run_check("post_reset_run", 4'b1000, 1, 2, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
